// File: rtl/mod_inv.sv
`default_nettype none
// ============================================================================
// Module      : mod_inv
// Description : Modular inverse r = a^-1 mod s using the binary extended
//               Euclidean algorithm, one step per clock. Three-state control
//               (IDLE -> RUN -> FIN). Reports err when no inverse exists or
//               when the operands are out of range.
//               Optional macro MOD_INV_TIMEOUT_EN adds an iteration counter
//               that forces an error termination after 4*FIELD_WIDTH+1 RUN
//               cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_inv #(
  parameter int FIELD_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [FIELD_WIDTH-1:0] a,
  input  logic [FIELD_WIDTH-1:0] s,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [FIELD_WIDTH-1:0] r
);

  localparam int W = FIELD_WIDTH;
  localparam logic [W-1:0] C_ZERO = '0;
  localparam logic [W-1:0] C_ONE  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   u_q, u_d;
  logic [W-1:0]   v_q, v_d;
  logic [W-1:0]   x1_q, x1_d;
  logic [W-1:0]   x2_q, x2_d;
  logic [W-1:0]   s_q, s_d;
  logic [W-1:0]   r_q, r_d;
  logic           err_q, err_d;
  logic           timeout_hit;

  // Halve x modulo m (m odd): an odd x is first lifted by m so the sum is even.
  // The sum needs one extra bit before the shift brings it back into range.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x,
                                            input logic [W-1:0] m);
    half_mod = W'(({1'b0, x} + (x[0] ? {1'b0, m} : {(W+1){1'b0}})) >> 1);
  endfunction

  // (x - y) mod m for x, y in [0, m-1]; the W-bit wraparound of x - y + m
  // lands exactly on the correct residue when the raw difference is negative.
  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic [W-1:0] m);
    sub_mod = (x >= y) ? (x - y) : (x - y + m);
  endfunction

`ifdef MOD_INV_TIMEOUT_EN
  localparam int           CW         = $clog2(4*W + 2);
  localparam logic [CW-1:0] C_TMO_LAST = CW'(4*W);

  logic [CW-1:0] iter_q, iter_d;

  // Iteration counter: cleared on an accepted start, counts RUN cycles.
  always_comb begin
    iter_d = iter_q;
    if (state_q == IDLE && start) begin
      iter_d = '0;
    end else if (state_q == RUN) begin
      iter_d = iter_q + 1'b1;
    end
  end

  // Iteration counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  // The (4*W+1)-th RUN cycle without a natural termination gives up.
  assign timeout_hit = (state_q == RUN) && (iter_q == C_TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and datapath step: one extended-Euclid rule per RUN cycle.
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    s_d     = s_q;
    r_d     = r_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          u_d   = a;
          v_d   = s;
          x1_d  = C_ONE;
          x2_d  = C_ZERO;
          s_d   = s;
          err_d = 1'b0;
          // Zero or out-of-range operands cannot have an inverse.
          if (a == C_ZERO || a >= s) begin
            err_d   = 1'b1;
            r_d     = C_ZERO;
            state_d = FIN;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (u_q == C_ONE) begin
          r_d     = x1_q;
          state_d = FIN;
        end else if (v_q == C_ONE) begin
          r_d     = x2_q;
          state_d = FIN;
        end else if (u_q == C_ZERO || v_q == C_ZERO) begin
          // gcd(a, s) > 1: the subtraction chain reached zero.
          err_d   = 1'b1;
          r_d     = C_ZERO;
          state_d = FIN;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          r_d     = C_ZERO;
          state_d = FIN;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = half_mod(x1_q, s_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = half_mod(x2_q, s_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub_mod(x1_q, x2_q, s_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub_mod(x2_q, x1_q, s_q);
        end
      end

      FIN: begin
        // err only accompanies done; r stays until the next completion.
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      s_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      s_q     <= s_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);
  assign err  = err_q;
  assign r    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_inv.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_inv
// Description : Self-checking bench for mod_inv (FIELD_WIDTH = 16). A table of
//               directed vectors with hand-computed inverses, plus sequences
//               for ignored starts, reset abort and reset-over-start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_inv;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] s;
    logic [W-1:0] exp_r;
    logic         exp_err;
    int           max_lat;
    int           exact_lat;   // 0 = only the upper bound is checked
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] s;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] r;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs[12];

  mod_inv #(.FIELD_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .s     (s),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .r     (r)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Issue one operation from IDLE and check result, latency and done width.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] si,
                        input logic [W-1:0] er, input logic ee,
                        input int max_lat, input int exact, input string tag);
    int cyc;
    a = ai;
    s = si;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < max_lat) begin
      step();
      cyc++;
    end
    check({tag, " done within bound"}, {31'd0, done}, 32'd1);
    if (exact != 0) check({tag, " latency"}, cyc, exact);
    check({tag, " r"}, {16'd0, r}, {16'd0, er});
    check({tag, " err"}, {31'd0, err}, {31'd0, ee});
    step();
    check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    check({tag, " err cleared"}, {31'd0, err}, 32'd0);
    check({tag, " r held"}, {16'd0, r}, {16'd0, er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ndone;
    int cyc;
    logic [W-1:0] r_at_done;

    //          a          s           r           err   max exact
    vecs[0]  = '{16'd3,     16'd7,     16'd5,     1'b0, 66, 5};
    vecs[1]  = '{16'd6,     16'd7,     16'd6,     1'b0, 66, 0};
    vecs[2]  = '{16'd2,     16'd65521, 16'd32761, 1'b0, 66, 3};
    vecs[3]  = '{16'd1,     16'd65521, 16'd1,     1'b0, 66, 2};
    vecs[4]  = '{16'd0,     16'd7,     16'd0,     1'b1, 2,  0};
    vecs[5]  = '{16'd5,     16'd15,    16'd0,     1'b1, 66, 0};
    vecs[6]  = '{16'd3,     16'd65521, 16'd43681, 1'b0, 66, 0};
    vecs[7]  = '{16'd7,     16'd7,     16'd0,     1'b1, 2,  0};
    vecs[8]  = '{16'd4,     16'd9,     16'd7,     1'b0, 66, 0};
    vecs[9]  = '{16'd10,    16'd21,    16'd19,    1'b0, 66, 0};
    vecs[10] = '{16'd6,     16'd9,     16'd0,     1'b1, 66, 0};
    vecs[11] = '{16'd2,     16'd3,     16'd2,     1'b0, 66, 0};

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    s     = '0;
    step();
    step();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset err",  {31'd0, err},  32'd0);
    check("reset r",    {16'd0, r},    32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].s, vecs[i].exp_r, vecs[i].exp_err,
             vecs[i].max_lat, vecs[i].exact_lat, $sformatf("vec%0d", i));
      step();
    end

    // Second start two cycles into a run is ignored.
    a = 16'd3; s = 16'd7; start = 1'b1;
    step();
    start = 1'b0;
    check("ignored start busy", {31'd0, busy}, 32'd1);
    step();
    a = 16'd2; s = 16'd7; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    r_at_done = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        r_at_done = r;
      end
      step();
    end
    check("ignored start done count", ndone, 32'd1);
    check("ignored start r", {16'd0, r_at_done}, 32'd5);

    // Reset in the first RUN cycle of a=2, s=65521 (whose run is only two
    // steps long) aborts it with no done.
    a = 16'd2; s = 16'd65521; start = 1'b1;
    step();
    start = 1'b0;
    check("abort busy before reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort r",    {16'd0, r},    32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      step();
    end
    check("abort no done", ndone, 32'd0);

    // Reset three cycles into a long run, then start right after release.
    a = 16'd3; s = 16'd65521; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("long run busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("long abort busy", {31'd0, busy}, 32'd0);
    check("long abort done", {31'd0, done}, 32'd0);
    a = 16'd3; s = 16'd7; start = 1'b1;
    step();
    start = 1'b0;
    check("restart accepted", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 66) begin
      step();
      cyc++;
    end
    check("restart latency", cyc, 32'd5);
    check("restart r",   {16'd0, r},   32'd5);
    check("restart err", {31'd0, err}, 32'd0);
    step();

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1; a = 16'd3; s = 16'd7;
    step();
    check("reset over start busy", {31'd0, busy}, 32'd0);
    check("reset over start done", {31'd0, done}, 32'd0);
    reset = 1'b0; start = 1'b0;
    step();
    check("idle after reset busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
